sdpram_arbiter: RTL and testbench

- Shares one simple dual-port RAM (write port A, read port B, 16-bit data, 256 entries, registered read) among NREQ requesters.
- Write and read ports are arbitrated independently, each round-robin with a valid/grant handshake.
- RAM controls are registered; read data returns to the winning requester with a tag.
- Sits between client blocks and the RAM instance; the RAM itself lives outside this block.

---
 rtl/sdpram_arb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/sdpram_arbiter.sv | 151 +++++++++++++++
 tb/tb_sdpram_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdpram_arb_pkg.sv
// rtl/sdpram_arb_pkg.sv - shared constants, ID width helper and response-stage type for sdpram_arbiter
package sdpram_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 8;
  localparam int DW_DEF   = 16;
  // Widest requester ID needed for the supported NREQ range (2..8)
  localparam int IDW_MAX  = 3;

  // Requester ID width for a requester count; at least one bit
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int IDW_DEF = id_width(NREQ_DEF);

  // Last read-pipeline stage: response valid, owner and optional bypass data
  typedef struct packed {
    logic               valid;
    logic [IDW_MAX-1:0] id;
    logic               fwd;
    logic [DW_DEF-1:0]  fwd_data;
  } rsp_stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot combinational grant and registered pointer
module rr_arbiter
  import sdpram_arb_pkg::*;
#(
  parameter int N  = NREQ_DEF,
  parameter int IW = id_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] pos;
  logic          found;

  // Pick the first request at or above the pointer; N is a power of two so IW-bit sums wrap mod N
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos = ptr_q + IW'(k);
      if (!found && req[pos]) begin
        found   = 1'b1;
        gnt_idx = pos;
      end
    end
    if (found) begin
      gnt[gnt_idx] = 1'b1;
    end
    ptr_d = found ? gnt_idx + IW'(1) : ptr_q;
  end

  // Pointer moves past the winner only on cycles that grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sdpram_arbiter.sv
// rtl/sdpram_arbiter.sv - round-robin sharing of one SDP RAM write/read port pair; SDPRAM_ARB_WR_FWD_EN enables write-to-read bypass
module sdpram_arbiter
  import sdpram_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    wr_req,
  input  logic [NREQ*AW-1:0] wr_addr,
  input  logic [NREQ*DW-1:0] wr_data,
  output logic [NREQ-1:0]    wr_gnt,
  input  logic [NREQ-1:0]    rd_req,
  input  logic [NREQ*AW-1:0] rd_addr,
  output logic [NREQ-1:0]    rd_gnt,
  output logic               ram_wea,
  output logic [AW-1:0]      ram_addra,
  output logic [DW-1:0]      ram_data_a,
  output logic               ram_enb,
  output logic [AW-1:0]      ram_addrb,
  input  logic [DW-1:0]      ram_data_b,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_data
);

  logic [IDW-1:0] wr_idx, rd_idx;

  logic           ram_wea_q, ram_wea_d;
  logic [AW-1:0]  ram_addra_q, ram_addra_d;
  logic [DW-1:0]  ram_data_a_q, ram_data_a_d;
  logic           ram_enb_q, ram_enb_d;
  logic [AW-1:0]  ram_addrb_q, ram_addrb_d;
  logic [IDW-1:0] rd_id_q, rd_id_d;

  rr_arbiter #(.N(NREQ), .IW(IDW)) u_wr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (wr_req),
    .gnt     (wr_gnt),
    .gnt_idx (wr_idx)
  );

  rr_arbiter #(.N(NREQ), .IW(IDW)) u_rd_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (rd_req),
    .gnt     (rd_gnt),
    .gnt_idx (rd_idx)
  );

  // Capture the winning slice of each port; address/data hold when the port is idle
  always_comb begin
    ram_wea_d    = |wr_gnt;
    ram_addra_d  = ram_addra_q;
    ram_data_a_d = ram_data_a_q;
    ram_enb_d    = |rd_gnt;
    ram_addrb_d  = ram_addrb_q;
    rd_id_d      = rd_id_q;
    if (|wr_gnt) begin
      ram_addra_d  = wr_addr[int'(wr_idx)*AW +: AW];
      ram_data_a_d = wr_data[int'(wr_idx)*DW +: DW];
    end
    if (|rd_gnt) begin
      ram_addrb_d = rd_addr[int'(rd_idx)*AW +: AW];
      rd_id_d     = rd_idx;
    end
  end

  // RAM control stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_wea_q    <= 1'b0;
      ram_addra_q  <= '0;
      ram_data_a_q <= '0;
      ram_enb_q    <= 1'b0;
      ram_addrb_q  <= '0;
      rd_id_q      <= '0;
    end else begin
      ram_wea_q    <= ram_wea_d;
      ram_addra_q  <= ram_addra_d;
      ram_data_a_q <= ram_data_a_d;
      ram_enb_q    <= ram_enb_d;
      ram_addrb_q  <= ram_addrb_d;
      rd_id_q      <= rd_id_d;
    end
  end

  assign ram_wea    = ram_wea_q;
  assign ram_addra  = ram_addra_q;
  assign ram_data_a = ram_data_a_q;
  assign ram_enb    = ram_enb_q;
  assign ram_addrb  = ram_addrb_q;

`ifdef SDPRAM_ARB_WR_FWD_EN
  rsp_stage_t rsp_q, rsp_d;
  logic       collide;

  // Same-cycle write and read to one address: the read-first RAM returns stale data, so keep the new word
  assign collide = ram_wea_q & ram_enb_q & (ram_addra_q == ram_addrb_q);

  // Response stage contents, aligned with the RAM's registered read data
  always_comb begin
    rsp_d.valid    = ram_enb_q;
    rsp_d.id       = IDW_MAX'(rd_id_q);
    rsp_d.fwd      = collide;
    rsp_d.fwd_data = DW_DEF'(ram_data_a_q);
  end

  // Response stage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  assign rsp_valid = rsp_q.valid;
  assign rsp_id    = IDW'(rsp_q.id);
  assign rsp_data  = rsp_q.fwd ? DW'(rsp_q.fwd_data) : ram_data_b;
`else
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;

  // Response stage contents, aligned with the RAM's registered read data
  always_comb begin
    rsp_valid_d = ram_enb_q;
    rsp_id_d    = rd_id_q;
  end

  // Response stage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = ram_data_b;
`endif

endmodule

// File: tb/tb_sdpram_arbiter.sv
// tb/tb_sdpram_arbiter.sv - self-checking bench for sdpram_arbiter with a read-first RAM model
module tb_sdpram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  wr_req, rd_req;
  logic [31:0] wr_addr, rd_addr;
  logic [63:0] wr_data;
  logic [3:0]  wr_gnt, rd_gnt;
  logic        ram_wea, ram_enb;
  logic [7:0]  ram_addra, ram_addrb;
  logic [15:0] ram_data_a, ram_data_b, rsp_data;
  logic        rsp_valid;
  logic [1:0]  rsp_id;

  sdpram_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_gnt     (wr_gnt),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_gnt     (rd_gnt),
    .ram_wea    (ram_wea),
    .ram_addra  (ram_addra),
    .ram_data_a (ram_data_a),
    .ram_enb    (ram_enb),
    .ram_addrb  (ram_addrb),
    .ram_data_b (ram_data_b),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
  );

  always #5 clk = ~clk;

  // Read-first RAM with registered read data
  bit [15:0] mem [256];
  always @(posedge clk) begin
    if (ram_enb) ram_data_b <= mem[ram_addrb];
    if (ram_wea) mem[ram_addra] <= ram_data_a;
  end

  typedef struct {
    int          id;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [3:0] wq;
    logic [3:0] rq;
    logic [3:0] ewg;
    logic [3:0] erg;
  } vec_t;

  exp_t      sbq[$];
  bit [15:0] shadow [256];
  int        n_checks = 0;
  int        n_fail   = 0;
  int        cyc      = 0;
  logic [7:0]  last_wa, last_ra;
  logic [15:0] last_wd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        e = sbq.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        if (rsp_valid === 1'b1) begin
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_data", 32'(rsp_data), 32'(e.data));
        end
      end else if (rsp_valid !== 1'b0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end
    end
  endtask

  // Called at a falling edge; drives one cycle of requests and checks grants and the RAM stage that follows
  task automatic apply(input logic [3:0] wq, input logic [31:0] wa, input logic [63:0] wd,
                       input logic [3:0] rq, input logic [31:0] ra,
                       input logic [3:0] ewg, input logic [3:0] erg, input string tag);
    int          wi, ri;
    logic [7:0]  a, raddr;
    logic [15:0] d, rdd;
    exp_t        e;
    wr_req = wq; wr_addr = wa; wr_data = wd;
    rd_req = rq; rd_addr = ra;
    #1;
    check({tag, " wr_gnt"}, 32'(wr_gnt), 32'(ewg));
    check({tag, " rd_gnt"}, 32'(rd_gnt), 32'(erg));
    wi = oh_idx(ewg);
    ri = oh_idx(erg);
    a  = wa[wi*8 +: 8];
    d  = wd[wi*16 +: 16];
    if (erg != 4'b0) begin
      raddr = ra[ri*8 +: 8];
      rdd   = shadow[raddr];
`ifdef SDPRAM_ARB_WR_FWD_EN
      if (ewg != 4'b0 && a == raddr) rdd = d;
`endif
      e.id = ri; e.data = rdd; e.cyc = cyc + 2;
      sbq.push_back(e);
      last_ra = raddr;
    end
    if (ewg != 4'b0) begin
      shadow[a] = d;
      last_wa = a;
      last_wd = d;
    end
    @(negedge clk);
    check({tag, " ram_wea"}, 32'(ram_wea), 32'(ewg != 4'b0));
    check({tag, " ram_enb"}, 32'(ram_enb), 32'(erg != 4'b0));
    check({tag, " ram_addra"}, 32'(ram_addra), 32'(last_wa));
    check({tag, " ram_data_a"}, 32'(ram_data_a), 32'(last_wd));
    check({tag, " ram_addrb"}, 32'(ram_addrb), 32'(last_ra));
    wr_req = 4'b0;
    rd_req = 4'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(4'b0, 32'h0, 64'h0, 4'b0, 32'h0, 4'b0, 4'b0, "idle");
  endtask

  initial begin
    vec_t        tbl [20];
    logic [31:0] wa, ra;
    logic [63:0] wd;

    tbl[0]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0001};
    tbl[1]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0010};
    tbl[2]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0100};
    tbl[3]  = '{4'b0000, 4'b1111, 4'b0000, 4'b1000};
    tbl[4]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0001};
    tbl[5]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0010};
    tbl[6]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0100};
    tbl[7]  = '{4'b0000, 4'b1111, 4'b0000, 4'b1000};
    tbl[8]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b0000, 4'b0010, 4'b0000, 4'b0010};
    tbl[10] = '{4'b0000, 4'b1010, 4'b0000, 4'b1000};
    tbl[11] = '{4'b0000, 4'b0010, 4'b0000, 4'b0010};
    tbl[12] = '{4'b0010, 4'b0001, 4'b0010, 4'b0001};
    tbl[13] = '{4'b1101, 4'b0000, 4'b0100, 4'b0000};
    tbl[14] = '{4'b1001, 4'b0000, 4'b1000, 4'b0000};
    tbl[15] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
    tbl[16] = '{4'b0101, 4'b0000, 4'b0100, 4'b0000};
    tbl[17] = '{4'b1111, 4'b1111, 4'b1000, 4'b0010};
    tbl[18] = '{4'b1111, 4'b1111, 4'b0001, 4'b0100};
    tbl[19] = '{4'b0000, 4'b1000, 4'b0000, 4'b1000};

    rst_n = 1'b0;
    wr_req = 4'b0; rd_req = 4'b0;
    wr_addr = 32'h0; rd_addr = 32'h0; wr_data = 64'h0;
    last_wa = 8'h0; last_ra = 8'h0; last_wd = 16'h0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("reset ram_wea", 32'(ram_wea), 32'd0);
    check("reset ram_enb", 32'(ram_enb), 32'd0);
    check("reset ram_addra", 32'(ram_addra), 32'd0);
    check("reset ram_addrb", 32'(ram_addrb), 32'd0);
    check("reset ram_data_a", 32'(ram_data_a), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_id", 32'(rsp_id), 32'd0);
    rst_n = 1'b1;

    // Round-robin, sparse, concurrent and both-port vectors over a small address window
    for (int v = 0; v < 20; v++) begin
      for (int k = 0; k < 4; k++) begin
        wa[k*8 +: 8]   = 8'h40 + 8'($urandom_range(0, 7));
        ra[k*8 +: 8]   = 8'h40 + 8'($urandom_range(0, 7));
        wd[k*16 +: 16] = 16'($urandom);
      end
      apply(tbl[v].wq, wa, wd, tbl[v].rq, ra, tbl[v].ewg, tbl[v].erg, $sformatf("vec%0d", v));
    end
    idle(2);

    // Single write then read by another requester
    apply(4'b0001, 32'h0000_0010, 64'h0000_0000_0000_BEEF, 4'b0, 32'h0, 4'b0001, 4'b0, "wr_beef");
    idle(2);
    apply(4'b0, 32'h0, 64'h0, 4'b0100, 32'h0010_0000, 4'b0, 4'b0100, "rd_beef");
    @(negedge clk);
    check("beef rsp_valid", 32'(rsp_valid), 32'd1);
    check("beef rsp_id", 32'(rsp_id), 32'd2);
    check("beef rsp_data", 32'(rsp_data), 32'h0000_BEEF);

    // Same-cycle write and read of one address
    apply(4'b0010, 32'h0000_2000, 64'h0000_0000_1111_0000, 4'b0, 32'h0, 4'b0010, 4'b0, "wr_1111");
    apply(4'b1000, 32'h2000_0000, 64'h2222_0000_0000_0000, 4'b0001, 32'h0000_0020,
          4'b1000, 4'b0001, "collide");
    @(negedge clk);
    check("collide rsp_valid", 32'(rsp_valid), 32'd1);
`ifdef SDPRAM_ARB_WR_FWD_EN
    check("collide rsp_data", 32'(rsp_data), 32'h0000_2222);
`else
    check("collide rsp_data", 32'(rsp_data), 32'h0000_1111);
`endif
    idle(2);

    // Reset one cycle after a read grant drops the read
    apply(4'b0, 32'h0, 64'h0, 4'b0100, 32'h0010_0000, 4'b0, 4'b0100, "rd_before_rst");
    rst_n = 1'b0;
    sbq.delete();
    #1;
    check("rst ram_enb", 32'(ram_enb), 32'd0);
    check("rst ram_addrb", 32'(ram_addrb), 32'd0);
    check("rst ram_addra", 32'(ram_addra), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rst quiet%0d", i), 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    last_wa = 8'h0; last_ra = 8'h0; last_wd = 16'h0;

    // Pointers restart at requester 0 on both ports
    apply(4'b1111, 32'h4344_4546, 64'h1234_5678_9ABC_DEF0, 4'b1111, 32'h4142_4344,
          4'b0001, 4'b0001, "post_rst0");
    apply(4'b1111, 32'h4748_4142, 64'h0F0E_0D0C_0B0A_0908, 4'b1111, 32'h4546_4748,
          4'b0010, 4'b0010, "post_rst1");
    idle(3);
    check("scoreboard drained", 32'(sbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
